fpadd_accum_driver: RTL



---
 rtl/fpadd_accum_driver.sv | 119 +++++++++++
 1 files changed

// File: rtl/fpadd_accum_driver.sv
// fpadd_accum_driver: folds FP32 packets into a running sum through an external start/done adder.
// Optional FPADD_DRV_ZERO_BYPASS_EN: +/-0 elements after the first are counted but never sent to the adder.
module fpadd_accum_driver #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             out_timeout,
  output logic             add_start,
  output logic [31:0]      add_a,
  output logic [31:0]      add_b,
  input  logic [31:0]      add_sum,
  input  logic             add_done,
  output logic             busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HOLD, S_ISSUE, S_SETTLE, S_WAIT, S_DRAIN, S_OUT
  } state_t;

  state_t           state;
  logic [31:0]      acc;
  logic [31:0]      opb;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_inc;
  logic             err;
  logic             last_q;
  logic [TW-1:0]    timer;
  logic             zero_skip;

  assign count_inc = (count == '1) ? count : count + CNT_W'(1);

`ifdef FPADD_DRV_ZERO_BYPASS_EN
  assign zero_skip = (in_data[30:0] == 31'd0);
`else
  assign zero_skip = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      acc    <= '0;
      opb    <= '0;
      count  <= '0;
      err    <= 1'b0;
      last_q <= 1'b0;
      timer  <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          acc   <= in_data;
          count <= CNT_W'(1);
          state <= in_last ? S_OUT : S_HOLD;
        end
        S_HOLD: if (in_valid) begin
          count <= count_inc;
          if (zero_skip) begin
            if (in_last) state <= S_OUT;
          end else begin
            opb    <= in_data;
            last_q <= in_last;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_SETTLE;
        // A done level left over from the previous add is not trusted here.
        S_SETTLE: begin
          timer <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (add_done) begin
            acc   <= add_sum;
            state <= last_q ? S_OUT : S_HOLD;
          end else if (timer == T_LAST) begin
            err   <= 1'b1;
            state <= last_q ? S_OUT : S_DRAIN;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DRAIN: if (in_valid) begin
          count <= count_inc;
          if (in_last) state <= S_OUT;
        end
        S_OUT: if (out_ready) begin
          acc   <= '0;
          count <= '0;
          err   <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state == S_IDLE) || (state == S_HOLD) || (state == S_DRAIN);
  assign out_valid   = (state == S_OUT);
  assign add_start   = (state == S_ISSUE);
  assign busy        = (state != S_IDLE);
  assign out_sum     = acc;
  assign out_count   = count;
  assign out_timeout = err;
  assign add_a       = acc;
  assign add_b       = opb;

endmodule
